ahb_sram_prph: RTL and testbench

- AHB5 subordinate (peripheral) that terminates the controller's transfers in an on-chip, word-organised SRAM.
- Sits on the peripheral side of the single-controller AHB interface:
  - consumes the address/control/write-data signals broadcast to peripherals, plus its decoder select;
  - drives rData/ready/resp into the response mux.
- Supports configurable wait states, byte-lane write strobes, and a two-cycle ERROR response for illegal transfers.

---
 rtl/ahb_sram_prph_if.sv | 44 ++++
 rtl/ahb_sram_prph.sv | 169 ++++++++++++++++
 tb/tb_ahb_sram_prph.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_prph_if.sv
// ---------------------------------------------------------------------------
// ahb_sram_prph_if
//   Peripheral-side AHB5 signal bundle for ahb_sram_prph.
//   master : the bus side (controller broadcast + decoder select + ready mux)
//   slave  : the SRAM peripheral
//   Signals:
//     sel       decoder select, address-phase timed
//     addr      byte address
//     trans     0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//     write     1 = write, 0 = read
//     size      log2 of transfer bytes
//     wData     write data, data-phase timed
//     wStrb     write byte strobes, data-phase timed
//     readyIn   bus-wide ready from the response mux
//     rData     read data from the peripheral
//     readyOut  peripheral ready to the mux
//     resp      0 OKAY, 1 ERROR
// ---------------------------------------------------------------------------
interface ahb_sram_prph_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
);
    logic                   sel;
    logic [AddrWidth-1:0]   addr;
    logic [1:0]             trans;
    logic                   write;
    logic [2:0]             size;
    logic [DataWidth-1:0]   wData;
    logic [DataWidth/8-1:0] wStrb;
    logic                   readyIn;
    logic [DataWidth-1:0]   rData;
    logic                   readyOut;
    logic                   resp;

    modport master (
        output sel, addr, trans, write, size, wData, wStrb, readyIn,
        input  rData, readyOut, resp
    );

    modport slave (
        input  sel, addr, trans, write, size, wData, wStrb, readyIn,
        output rData, readyOut, resp
    );
endinterface

// File: rtl/ahb_sram_prph.sv
// ---------------------------------------------------------------------------
// ahb_sram_prph
//   AHB5 subordinate terminating transfers in a word-organised on-chip SRAM.
//   Configurable wait states, byte-lane write strobes, two-cycle ERROR
//   response for out-of-range, oversized or misaligned transfers.
//   Ports:
//     clk     clock
//     nReset  asynchronous active-low reset
//     bus     ahb_sram_prph_if.slave (parameters must match this module's)
//   Assumes Depth is a power of two >= 2 and AddrWidth >= 8.
// ---------------------------------------------------------------------------
module ahb_sram_prph #(
    parameter int DataWidth  = 32,
    parameter int AddrWidth  = 32,
    parameter int Depth      = 256,
    parameter int WaitStates = 0
) (
    input  logic           clk,
    input  logic           nReset,
    ahb_sram_prph_if.slave bus
);
    localparam int ByteLanes = DataWidth / 8;
    localparam int ByteLog   = $clog2(ByteLanes);
    localparam int IdxW      = $clog2(Depth);
    localparam logic [AddrWidth:0] ByteLimit = (AddrWidth+1)'(Depth * ByteLanes);
    localparam logic HasWait  = (WaitStates > 0);
    localparam logic [3:0] WaitLast = (WaitStates > 0) ? 4'(WaitStates - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t               state_reg, state_next;
    logic [3:0]           wait_cnt_reg, wait_cnt_next;
    logic [IdxW-1:0]      idx_reg;
    logic                 write_reg;
    logic [DataWidth-1:0] rdata_reg;

    logic                 ready_state;
    logic                 accept;
    logic                 illegal_in;
    logic                 load;
    logic [7:0]           align_mask;
    logic [IdxW-1:0]      in_idx;
    logic [IdxW-1:0]      rd_idx;
    logic                 rd_en;
    logic                 mem_we;
    logic                 fwd_hit;
    logic [DataWidth-1:0] rd_word;

    logic [DataWidth-1:0] mem [Depth];

    // Address-phase decode. The legality test is applied to the same values
    // that get latched, so the verdict is resolved at the latch edge and only
    // the resulting state is carried into the data phase.
    assign in_idx = bus.addr[ByteLog +: IdxW];

    always_comb begin
        align_mask = (8'd1 << bus.size) - 8'd1;
        illegal_in = ({1'b0, bus.addr} >= ByteLimit)
                   || (bus.size > 3'(ByteLog))
                   || (|(bus.addr[7:0] & align_mask));
    end

    // Only states that drive ready high can take a new address phase.
    assign ready_state = (state_reg == ST_IDLE) || (state_reg == ST_DATA)
                      || (state_reg == ST_ERR2);
    assign accept      = ready_state && bus.sel && bus.readyIn && bus.trans[1];

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        load          = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept) begin
                    load = 1'b1;
                    if (illegal_in) begin
                        state_next = ST_ERR1;
                    end else if (HasWait) begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = 4'd0;
                    end else begin
                        state_next = ST_DATA;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == WaitLast) begin
                    state_next = ST_DATA;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 4'd1;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 4'd0;
            idx_reg      <= '0;
            write_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (load) begin
                idx_reg   <= in_idx;
                write_reg <= bus.write;
            end
        end
    end

    // The SRAM read is issued on the edge that enters DATA so rData is valid
    // for the whole DATA cycle: the accept edge with no wait states, else the
    // last WAIT edge using the latched index.
    always_comb begin
        rd_en  = 1'b0;
        rd_idx = idx_reg;
        if (load && !illegal_in && !bus.write && !HasWait) begin
            rd_en  = 1'b1;
            rd_idx = in_idx;
        end else if ((state_reg == ST_WAIT) && (wait_cnt_reg == WaitLast) && !write_reg) begin
            rd_en = 1'b1;
        end
    end

    // The write commits on the edge ending DATA. A read issued on that same
    // edge to the same word takes the strobed bytes from wData (write-first).
    // state_reg clears asynchronously, so reset suppresses any pending write.
    assign mem_we  = (state_reg == ST_DATA) && write_reg;
    assign fwd_hit = mem_we && (rd_idx == idx_reg);

    for (genvar gi = 0; gi < ByteLanes; gi++) begin : g_lane
        assign rd_word[gi*8 +: 8] = (fwd_hit && bus.wStrb[gi]) ? bus.wData[gi*8 +: 8]
                                                                : mem[rd_idx][gi*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < ByteLanes; i++) begin
                if (bus.wStrb[i]) begin
                    mem[idx_reg][i*8 +: 8] <= bus.wData[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rdata_reg <= '0;
        end else if (rd_en) begin
            rdata_reg <= rd_word;
        end
    end

    assign bus.rData    = rdata_reg;
    assign bus.readyOut = (state_reg != ST_WAIT) && (state_reg != ST_ERR1);
    assign bus.resp     = (state_reg == ST_ERR1) || (state_reg == ST_ERR2);

endmodule

// File: tb/tb_ahb_sram_prph.sv
module tb_ahb_sram_prph;
    logic clk = 1'b0;
    logic nReset = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        resp;
        logic        chk_data;
        logic [31:0] data;
        int          waits;
        logic        low_resp;
    } exp_t;

    exp_t exp_q[2][$];

    logic        sel_v   [2];
    logic [1:0]  trans_v [2];
    logic [31:0] addr_v  [2];
    logic        write_v [2];
    logic [2:0]  size_v  [2];
    logic [31:0] wdata_v [2];
    logic [3:0]  wstrb_v [2];
    logic [31:0] pend_wd [2];
    logic [3:0]  pend_ws [2];
    logic        ready_w [2];
    logic        resp_w  [2];
    logic [31:0] rdata_w [2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s dut%0d: got %h required %h", name, d, act, req);
    endtask

    // dut0: WaitStates = 0, dut1: WaitStates = 2
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        ahb_sram_prph_if #(.DataWidth(32), .AddrWidth(32)) bus ();

        assign bus.sel     = sel_v[gi];
        assign bus.trans   = trans_v[gi];
        assign bus.addr    = addr_v[gi];
        assign bus.write   = write_v[gi];
        assign bus.size    = size_v[gi];
        assign bus.wData   = wdata_v[gi];
        assign bus.wStrb   = wstrb_v[gi];
        assign bus.readyIn = bus.readyOut;
        assign ready_w[gi] = bus.readyOut;
        assign resp_w[gi]  = bus.resp;
        assign rdata_w[gi] = bus.rData;

        ahb_sram_prph #(
            .DataWidth (32),
            .AddrWidth (32),
            .Depth     (256),
            .WaitStates(gi * 2)
        ) dut (
            .clk   (clk),
            .nReset(nReset),
            .bus   (bus)
        );

        // Monitor: tracks data phases from observed address-phase handshakes
        // and checks each completed transfer against the scoreboard.
        initial begin
            bit   in_d = 1'b0;
            int   waits = 0;
            logic low_or = 1'b0;
            exp_t e;
            forever begin
                @(negedge clk);
                if (!nReset) begin
                    in_d = 1'b0;
                end else begin
                    if (in_d) begin
                        if (!ready_w[gi]) begin
                            waits++;
                            low_or = low_or | resp_w[gi];
                        end else begin
                            in_d = 1'b0;
                            if (exp_q[gi].size() == 0) begin
                                n_checks++;
                                $display("FAIL unexpected_txn dut%0d: got a transfer, required none", gi);
                            end else begin
                                e = exp_q[gi].pop_front();
                                $display("[%0t] dut%0d txn resp=%0d waits=%0d rdata=%h", $time, gi,
                                         resp_w[gi], waits, rdata_w[gi]);
                                chk("waits", gi, 32'(waits), 32'(e.waits));
                                chk("resp", gi, {31'd0, resp_w[gi]}, {31'd0, e.resp});
                                if (e.waits > 0) chk("low_resp", gi, {31'd0, low_or}, {31'd0, e.low_resp});
                                if (e.chk_data) chk("rdata", gi, rdata_w[gi], e.data);
                            end
                        end
                    end
                    if (sel_v[gi] && trans_v[gi][1] && ready_w[gi]) begin
                        in_d   = 1'b1;
                        waits  = 0;
                        low_or = 1'b0;
                    end
                end
            end
        end
    end

    function automatic int ws_of(input int d);
        return d * 2;
    endfunction

    // One address phase (plus the previous transfer's data phase); holds
    // until the peripheral is ready, then returns 1 ns after the edge.
    task automatic cyc(input int d, input logic s, input logic [1:0] tr, input logic [31:0] a,
                       input logic w, input logic [2:0] sz, input logic [31:0] wd, input logic [3:0] ws);
        int n = 0;
        wdata_v[d] = pend_wd[d];
        wstrb_v[d] = pend_ws[d];
        sel_v[d]   = s;
        trans_v[d] = tr;
        addr_v[d]  = a;
        write_v[d] = w;
        size_v[d]  = sz;
        pend_wd[d] = wd;
        pend_ws[d] = ws;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_w[d] && n < 50);
        if (!ready_w[d]) begin
            n_checks++;
            $display("FAIL ready_timeout dut%0d: ready=0 required 1", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input logic r, input logic c, input logic [31:0] data, input int wt, input logic lr);
        exp_t e;
        e.resp = r; e.chk_data = c; e.data = data; e.waits = wt; e.low_resp = lr;
        exp_q[d].push_back(e);
    endtask

    task automatic wr(input int d, input logic [1:0] tr, input logic [31:0] a, input logic [31:0] data, input logic [3:0] strb);
        push(d, 1'b0, 1'b0, 32'd0, ws_of(d), 1'b0);
        cyc(d, 1'b1, tr, a, 1'b1, 3'd2, data, strb);
    endtask

    task automatic rd(input int d, input logic [1:0] tr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] exp_data);
        push(d, 1'b0, 1'b1, exp_data, ws_of(d), 1'b0);
        cyc(d, 1'b1, tr, a, 1'b0, sz, 32'd0, 4'h0);
    endtask

    task automatic err(input int d, input logic w, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] held_rdata);
        push(d, 1'b1, 1'b1, held_rdata, 1, 1'b1);
        cyc(d, 1'b1, 2'b10, a, w, sz, 32'hFFFF_FFFF, 4'hF);
    endtask

    task automatic idle(input int d);
        cyc(d, 1'b0, 2'b00, 32'd0, 1'b0, 3'd2, 32'd0, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            sel_v[d] = 0; trans_v[d] = 0; addr_v[d] = 0; write_v[d] = 0; size_v[d] = 3'd2;
            wdata_v[d] = 0; wstrb_v[d] = 0; pend_wd[d] = 0; pend_ws[d] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", d, {31'd0, ready_w[d]}, 32'd1);
            chk("reset_resp", d, {31'd0, resp_w[d]}, 32'd0);
            chk("reset_rdata", d, rdata_w[d], 32'd0);
        end
        @(posedge clk);
        #1 nReset = 1'b1;

        // ---- zero wait states ----
        wr(0, 2'b10, 32'h10, 32'hDEAD_BEEF, 4'hF);
        idle(0);
        rd(0, 2'b10, 32'h10, 3'd2, 32'hDEAD_BEEF);
        wr(0, 2'b10, 32'h20, 32'h1122_3344, 4'hF);
        wr(0, 2'b10, 32'h20, 32'hAABB_CCDD, 4'h5);
        rd(0, 2'b10, 32'h20, 3'd2, 32'h11BB_33DD);
        rd(0, 2'b10, 32'h22, 3'd1, 32'h11BB_33DD);
        wr(0, 2'b10, 32'h0, 32'h1357_9BDF, 4'hF);
        err(0, 1'b0, 32'h400, 3'd2, 32'h11BB_33DD);
        err(0, 1'b1, 32'h402, 3'd2, 32'h11BB_33DD);
        err(0, 1'b1, 32'h12, 3'd2, 32'h11BB_33DD);
        err(0, 1'b0, 32'h10, 3'd3, 32'h11BB_33DD);
        rd(0, 2'b10, 32'h10, 3'd2, 32'hDEAD_BEEF);
        rd(0, 2'b10, 32'h0, 3'd2, 32'h1357_9BDF);
        wr(0, 2'b10, 32'h3FC, 32'h55AA_55AA, 4'hF);
        rd(0, 2'b10, 32'h3FC, 3'd2, 32'h55AA_55AA);
        wr(0, 2'b10, 32'h0, 32'hCAFE_F00D, 4'hF);
        wr(0, 2'b11, 32'h4, 32'h0102_0304, 4'hF);
        rd(0, 2'b11, 32'h0, 3'd2, 32'hCAFE_F00D);
        rd(0, 2'b11, 32'h4, 3'd2, 32'h0102_0304);
        idle(0);

        // ---- two wait states ----
        wr(1, 2'b10, 32'h10, 32'h0BAD_F00D, 4'hF);
        rd(1, 2'b10, 32'h10, 3'd2, 32'h0BAD_F00D);
        err(1, 1'b0, 32'h400, 3'd2, 32'h0BAD_F00D);
        wr(1, 2'b10, 32'h30, 32'h0000_0000, 4'hF);
        idle(1);

        // Reset in the WAIT phase of a write to 0x30.
        sel_v[1] = 1'b1; trans_v[1] = 2'b10; addr_v[1] = 32'h30; write_v[1] = 1'b1; size_v[1] = 3'd2;
        @(posedge clk);
        #1;
        sel_v[1] = 1'b0; trans_v[1] = 2'b00;
        wdata_v[1] = 32'h1234_5678; wstrb_v[1] = 4'hF;
        nReset = 1'b0;
        #1;
        chk("async_reset_ready", 1, {31'd0, ready_w[1]}, 32'd1);
        chk("async_reset_resp", 1, {31'd0, resp_w[1]}, 32'd0);
        chk("async_reset_rdata", 1, rdata_w[1], 32'd0);
        $display("[%0t] dut1 txn reset during write wait", $time);
        @(posedge clk);
        #1 nReset = 1'b1;
        rd(1, 2'b10, 32'h30, 3'd2, 32'h0000_0000);
        idle(1);

        begin
            int k = 0;
            while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
                n_checks++;
                $display("FAIL drain: %0d/%0d transfers outstanding, required 0", exp_q[0].size(), exp_q[1].size());
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
